seq_divider: RTL

//   Multi-cycle signed divider (MIPS DIV semantics) feeding the HI/LO register pair.

---
 rtl/seq_divider.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Signed restoring divider (MIPS DIV semantics): one quotient bit per clock, result WIDTH+2 cycles after start,
// 2 cycles for a zero divisor; start is only honoured in IDLE and is neither back-pressured nor queued otherwise.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_retire;

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz_op;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_quo_neg;
  logic [WIDTH-1:0] w_rem_neg;
  logic             w_divisor_zero;

  // Magnitudes stay WIDTH bits; -2^(W-1) maps onto itself and is read as unsigned.
  assign w_dvd_mag      = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvs_mag      = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_divisor_zero = (divisor == '0);

  // The shifted partial remainder needs WIDTH+1 bits; after a successful
  // subtraction it is below |divisor| again and fits back into WIDTH bits.
  assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_fits      = (w_rem_shift >= {1'b0, r_dvs});
  assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_dvs;

  assign w_quo_neg = -r_quo;
  assign w_rem_neg = -r_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_retire    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = w_divisor_zero ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_retire    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz_op  <= 1'b0;
    end else if (w_load) begin
      r_dz_op <= w_divisor_zero;
      if (!w_divisor_zero) begin
        r_quo    <= w_dvd_mag;
        r_rem    <= '0;
        r_dvs    <= w_dvs_mag;
        r_cnt    <= CW'(WIDTH);
        r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_sign_r <= dividend[WIDTH-1];
      end
    end else if (w_step) begin
      r_cnt <= r_cnt - CW'(1);
      r_rem <= w_fits ? w_rem_sub : w_rem_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
    end
  end

  // A zero-divisor operation only raises the flag; HI/LO keep the last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= w_retire;
      if (w_load && !w_divisor_zero) begin
        r_div_zero <= 1'b0;
      end else if (w_retire) begin
        if (r_dz_op) begin
          r_div_zero <= 1'b1;
        end else begin
          r_quotient  <= r_sign_q ? w_quo_neg : r_quo;
          r_remainder <= r_sign_r ? w_rem_neg : r_rem;
        end
      end
    end
  end

  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule
